// File: rtl/merger_pkg.sv
// Shared types for the merger tree controllers: widths, request descriptor,
// and the leaf scheduler FSM states.
package merger_pkg;

    localparam int NUM_LEAVES_P = 64;
    localparam int DATA_W_P     = 32;
    localparam int ADDR_W_P     = 32;
    localparam int LEN_W_P      = 24;
    localparam int FIFO_DEPTH_P = 16;
    localparam int BURST_P      = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LEAF_W_P = idx_w(NUM_LEAVES_P);
    localparam int RLEN_W_P = $clog2(BURST_P) + 1;

    typedef struct packed {
        logic [ADDR_W_P-1:0] addr;
        logic [RLEN_W_P-1:0] len;
        logic [LEAF_W_P-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping.
// N must be a power of two so the index wraps naturally.
module rr_arbiter
    import merger_pkg::*;
#(
    parameter int N = 64,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_o,
    output logic         valid_o
);

    logic [W-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr_i + W'(i);
            if (!valid_o && req_i[idx]) begin
                gnt_o   = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/merger_leaf_scheduler.sv
// Credit-based refill scheduler for the merger tree leaf FIFOs: issues burst
// reads round-robin and steers tagged read responses into the leaf FIFOs.
module merger_leaf_scheduler
    import merger_pkg::*;
#(
    parameter int NUM_LEAVES = NUM_LEAVES_P,
    parameter int DATA_WIDTH = DATA_W_P,
    parameter int ADDR_WIDTH = ADDR_W_P,
    parameter int LEN_WIDTH  = LEN_W_P,
    parameter int FIFO_DEPTH = FIFO_DEPTH_P,
    parameter int BURST      = BURST_P
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_cfg_valid,
    input  logic [idx_w(NUM_LEAVES)-1:0] i_cfg_leaf,
    input  logic [ADDR_WIDTH-1:0]        i_cfg_addr,
    input  logic [LEN_WIDTH-1:0]         i_cfg_len,
    input  logic                         i_start,
    output logic                         o_req_valid,
    input  logic                         i_req_ready,
    output logic [ADDR_WIDTH-1:0]        o_req_addr,
    output logic [$clog2(BURST):0]       o_req_len,
    output logic [idx_w(NUM_LEAVES)-1:0] o_req_tag,
    input  logic                         i_rsp_valid,
    input  logic [idx_w(NUM_LEAVES)-1:0] i_rsp_tag,
    input  logic [DATA_WIDTH-1:0]        i_rsp_data,
    output logic [NUM_LEAVES-1:0]        o_leaf_write,
    output logic [DATA_WIDTH-1:0]        o_leaf_data,
    input  logic [NUM_LEAVES-1:0]        i_leaf_read,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int LW  = idx_w(NUM_LEAVES);
    localparam int RLW = $clog2(BURST) + 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int OW  = $clog2(NUM_LEAVES * FIFO_DEPTH + 1);

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q [NUM_LEAVES];
    logic [ADDR_WIDTH-1:0] addr_d [NUM_LEAVES];
    logic [LEN_WIDTH-1:0]  rem_q  [NUM_LEAVES];
    logic [LEN_WIDTH-1:0]  rem_d  [NUM_LEAVES];
    logic [CW-1:0]         cred_q [NUM_LEAVES];
    logic [CW-1:0]         cred_d [NUM_LEAVES];

    logic [OW-1:0]         out_q, out_d;
    logic [LW-1:0]         ptr_q, ptr_d;
    req_t                  req_q, req_d;
    logic                  req_vld_q, req_vld_d;
    logic [NUM_LEAVES-1:0] lw_q;
    logic [DATA_WIDTH-1:0] ld_q;

    logic [NUM_LEAVES-1:0] elig;
    logic [NUM_LEAVES-1:0] rem_nz;
    logic [LW-1:0]         gnt;
    logic                  gnt_vld;
    logic                  pick;
    logic [RLW-1:0]        n_g;

    function automatic logic [RLW-1:0] burst_len(
        input logic [LEN_WIDTH-1:0] rem
    );
        if (rem >= LEN_WIDTH'(BURST))
            return RLW'(BURST);
        return RLW'(rem);
    endfunction

    // A leaf may only be charged when its whole burst already has room.
    always_comb begin
        rem_nz = '0;
        elig   = '0;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            rem_nz[k] = |rem_q[k];
            elig[k]   = (state_q == ST_RUN) && rem_nz[k]
                      && (cred_q[k] >= CW'(burst_len(rem_q[k])));
        end
    end

    rr_arbiter #(
        .N (NUM_LEAVES),
        .W (LW)
    ) u_arb (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .valid_o (gnt_vld)
    );

    assign n_g  = burst_len(rem_q[gnt]);
    assign pick = gnt_vld && (!req_vld_q || i_req_ready);

    always_comb begin
        addr_d    = addr_q;
        rem_d     = rem_q;
        cred_d    = cred_q;
        out_d     = out_q;
        ptr_d     = ptr_q;
        req_d     = req_q;
        req_vld_d = req_vld_q;
        if (state_q == ST_IDLE) begin
            if (i_cfg_valid) begin
                addr_d[i_cfg_leaf] = i_cfg_addr;
                rem_d[i_cfg_leaf]  = i_cfg_len;
            end
            if (i_start) begin
                for (int k = 0; k < NUM_LEAVES; k++)
                    cred_d[k] = CW'(FIFO_DEPTH);
                out_d = '0;
            end
        end else begin
            for (int k = 0; k < NUM_LEAVES; k++)
                if (i_leaf_read[k])
                    cred_d[k] = cred_d[k] + CW'(1);
            if (req_vld_q && i_req_ready)
                req_vld_d = 1'b0;
            if (pick) begin
                addr_d[gnt] = addr_q[gnt] + ADDR_WIDTH'(n_g);
                rem_d[gnt]  = rem_q[gnt] - LEN_WIDTH'(n_g);
                cred_d[gnt] = cred_d[gnt] - CW'(n_g);
                out_d       = out_d + OW'(n_g);
                req_d.addr  = addr_q[gnt];
                req_d.len   = n_g;
                req_d.tag   = gnt;
                req_vld_d   = 1'b1;
                ptr_d       = gnt + LW'(1);
            end
            if (i_rsp_valid)
                out_d = out_d - OW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_LEAVES; k++) begin
                addr_q[k] <= '0;
                rem_q[k]  <= '0;
                cred_q[k] <= '0;
            end
            out_q     <= '0;
            ptr_q     <= '0;
            req_q     <= '0;
            req_vld_q <= 1'b0;
            lw_q      <= '0;
            ld_q      <= '0;
        end else begin
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            cred_q    <= cred_d;
            out_q     <= out_d;
            ptr_q     <= ptr_d;
            req_q     <= req_d;
            req_vld_q <= req_vld_d;
            lw_q      <= '0;
            if (i_rsp_valid && state_q != ST_IDLE) begin
                lw_q[i_rsp_tag] <= 1'b1;
                ld_q            <= i_rsp_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_RUN;
            ST_RUN:   if (~|rem_nz) state_d = ST_DRAIN;
            ST_DRAIN: if (out_q == '0 && !req_vld_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        o_done = (state_q == ST_DONE);
    end

    assign o_req_valid  = req_vld_q;
    assign o_req_addr   = req_q.addr;
    assign o_req_len    = req_q.len;
    assign o_req_tag    = req_q.tag;
    assign o_leaf_write = lw_q;
    assign o_leaf_data  = ld_q;

endmodule

// File: tb/tb_merger_leaf_scheduler.sv
// Directed bench for merger_leaf_scheduler with a memory responder
// and a per-leaf FIFO occupancy model on the tree side.
module tb_merger_leaf_scheduler;

    localparam int N     = 64;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_cfg_valid;
    logic [5:0]  i_cfg_leaf;
    logic [31:0] i_cfg_addr;
    logic [23:0] i_cfg_len;
    logic        i_start;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [31:0] o_req_addr;
    logic [3:0]  o_req_len;
    logic [5:0]  o_req_tag;
    logic        i_rsp_valid;
    logic [5:0]  i_rsp_tag;
    logic [31:0] i_rsp_data;
    logic [N-1:0] o_leaf_write;
    logic [31:0] o_leaf_data;
    logic [N-1:0] i_leaf_read;
    logic        o_busy;
    logic        o_done;

    always #5 clk = ~clk;

    merger_leaf_scheduler dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_cfg_valid  (i_cfg_valid),
        .i_cfg_leaf   (i_cfg_leaf),
        .i_cfg_addr   (i_cfg_addr),
        .i_cfg_len    (i_cfg_len),
        .i_start      (i_start),
        .o_req_valid  (o_req_valid),
        .i_req_ready  (i_req_ready),
        .o_req_addr   (o_req_addr),
        .o_req_len    (o_req_len),
        .o_req_tag    (o_req_tag),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_tag    (i_rsp_tag),
        .i_rsp_data   (i_rsp_data),
        .o_leaf_write (o_leaf_write),
        .o_leaf_data  (o_leaf_data),
        .i_leaf_read  (i_leaf_read),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    typedef struct {
        int          tag;
        logic [31:0] data;
    } rsp_t;

    int checks = 0;
    int errors = 0;

    logic ready_en, rsp_en, read_en, slow_rd, drop_mode;
    int   read_budget;
    rsp_t rspq[$];
    int   occ[N];
    int   enq_cnt[N];
    bit   ovf;
    int   enq_bad;
    int   cyc = 0;
    int   done_cnt, done_cyc, last_rsp_cyc, start_cyc;
    bit   sent_v;
    int   sent_tag;
    logic [31:0] sent_data;
    logic [31:0] rq_addr[$];
    int   rq_len[$];
    int   rq_tag[$];
    int   rq_cyc[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rq_addr.delete();
        rq_len.delete();
        rq_tag.delete();
        rq_cyc.delete();
    endtask

    // One clock: observe outputs #1 after the edge, then drive next inputs.
    task automatic tick();
        logic [N-1:0] exp_w;
        logic [N-1:0] rd;
        rsp_t r;
        @(posedge clk);
        #1;
        cyc++;
        exp_w = '0;
        if (sent_v && !drop_mode)
            exp_w[sent_tag] = 1'b1;
        if (o_leaf_write !== exp_w)
            enq_bad++;
        else if (exp_w != '0 && o_leaf_data !== sent_data)
            enq_bad++;
        for (int k = 0; k < N; k++)
            if (o_leaf_write[k]) enq_cnt[k]++;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        i_req_ready = ready_en;
        if (o_req_valid && ready_en) begin
            rq_addr.push_back(o_req_addr);
            rq_len.push_back(int'(o_req_len));
            rq_tag.push_back(int'(o_req_tag));
            rq_cyc.push_back(cyc);
            for (int i = 0; i < int'(o_req_len); i++)
                rspq.push_back('{tag: int'(o_req_tag),
                                 data: o_req_addr + 32'(i)});
        end
        sent_v = 1'b0;
        i_rsp_valid = 1'b0;
        if (rsp_en && rspq.size() > 0) begin
            r = rspq.pop_front();
            i_rsp_valid = 1'b1;
            i_rsp_tag   = 6'(r.tag);
            i_rsp_data  = r.data;
            sent_v      = 1'b1;
            sent_tag    = r.tag;
            sent_data   = r.data;
            last_rsp_cyc = cyc;
        end
        rd = '0;
        for (int k = 0; k < N; k++) begin
            if (read_en && occ[k] > 0 && read_budget != 0
                && (!slow_rd || cyc % 2 == 0)) begin
                rd[k] = 1'b1;
                if (read_budget > 0) read_budget--;
            end
        end
        i_leaf_read = rd;
        for (int k = 0; k < N; k++) begin
            occ[k] = occ[k] + int'(o_leaf_write[k]) - int'(rd[k]);
            if (occ[k] > DEPTH) ovf = 1'b1;
        end
    endtask

    task automatic reset_dut();
        i_rst = 1'b1;
        i_cfg_valid = 1'b0;
        i_cfg_leaf = '0;
        i_cfg_addr = '0;
        i_cfg_len = '0;
        i_start = 1'b0;
        i_req_ready = 1'b0;
        i_rsp_valid = 1'b0;
        i_rsp_tag = '0;
        i_rsp_data = '0;
        i_leaf_read = '0;
        ready_en = 1'b0;
        rsp_en = 1'b0;
        read_en = 1'b0;
        slow_rd = 1'b0;
        drop_mode = 1'b0;
        read_budget = -1;
        rspq.delete();
        clear_logs();
        for (int k = 0; k < N; k++) begin
            occ[k] = 0;
            enq_cnt[k] = 0;
        end
        ovf = 1'b0;
        done_cnt = 0;
        sent_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic cfg(input int leaf, input logic [31:0] addr,
                       input int len);
        i_cfg_valid = 1'b1;
        i_cfg_leaf  = 6'(leaf);
        i_cfg_addr  = addr;
        i_cfg_len   = 24'(len);
        tick();
        i_cfg_valid = 1'b0;
    endtask

    task automatic start();
        start_cyc = cyc;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({tag, "_done"}, 64'(done_cnt), 1);
        check({tag, "_idle"}, 64'(o_busy), 0);
    endtask

    task automatic go(input logic rdy, input logic rsp, input logic rde);
        ready_en = rdy;
        rsp_en   = rsp;
        read_en  = rde;
    endtask

    int bad;
    logic [31:0] h_addr;
    logic [3:0]  h_len;
    logic [5:0]  h_tag;

    initial begin
        enq_bad = 0;
        reset_dut();
        check("rst_req_valid", 64'(o_req_valid), 0);
        check("rst_req_addr", 64'(o_req_addr), 0);
        check("rst_req_len", 64'(o_req_len), 0);
        check("rst_req_tag", 64'(o_req_tag), 0);
        check("rst_leaf_write", 64'(o_leaf_write), 0);
        check("rst_leaf_data", 64'(o_leaf_data), 0);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_done", 64'(o_done), 0);

        // Single leaf 5, 20 items: bursts 8, 8, 4.
        cfg(5, 32'h1000, 20);
        go(1'b1, 1'b1, 1'b1);
        start();
        run_until_done("a", 500);
        check("a_nreq", 64'(rq_addr.size()), 3);
        if (rq_addr.size() == 3) begin
            check("a_addr0", 64'(rq_addr[0]), 64'h1000);
            check("a_addr1", 64'(rq_addr[1]), 64'h1008);
            check("a_addr2", 64'(rq_addr[2]), 64'h1010);
            check("a_len0", 64'(rq_len[0]), 8);
            check("a_len1", 64'(rq_len[1]), 8);
            check("a_len2", 64'(rq_len[2]), 4);
            check("a_tags", 64'(rq_tag[0] + rq_tag[1] + rq_tag[2]), 15);
            check("a_latency", 64'(rq_cyc[0]), 64'(start_cyc + 2));
        end
        check("a_enq", 64'(enq_cnt[5]), 20);
        check("a_done_at", 64'(done_cyc), 64'(last_rsp_cyc + 2));

        // All leaves len 8 with ready held: tags 0..63 back to back.
        reset_dut();
        for (int k = 0; k < N; k++)
            cfg(k, 32'(k * 256), 8);
        go(1'b1, 1'b1, 1'b1);
        start();
        tick();
        check("b_first_valid", 64'(o_req_valid), 1);
        check("b_first_tag", 64'(o_req_tag), 0);
        check("b_busy", 64'(o_busy), 1);
        run_until_done("b", 3000);
        check("b_nreq", 64'(rq_tag.size()), 64);
        bad = 0;
        for (int i = 0; i < rq_tag.size(); i++)
            if (rq_tag[i] != i % N || rq_addr[i] != 32'(i * 256)) bad++;
        for (int k = 0; k < N; k++)
            if (enq_cnt[k] != 8) bad++;
        check("b_order", 64'(bad), 0);
        if (rq_cyc.size() == 64)
            check("b_b2b", 64'(rq_cyc[63] - rq_cyc[0]), 63);

        // Leaf 0 len 64, credit-limited by tree reads.
        reset_dut();
        cfg(0, 32'h2000, 64);
        go(1'b1, 1'b1, 1'b1);
        read_budget = 0;
        start();
        repeat (60) tick();
        check("c_stall", 64'(rq_addr.size()), 2);
        read_budget = 8;
        repeat (40) tick();
        check("c_after8", 64'(rq_addr.size()), 3);
        read_budget = 7;
        repeat (40) tick();
        check("c_after15", 64'(rq_addr.size()), 3);
        read_budget = 1;
        repeat (40) tick();
        check("c_after16", 64'(rq_addr.size()), 4);
        if (rq_addr.size() >= 3)
            check("c_addr2", 64'(rq_addr[2]), 64'h2010);
        read_budget = -1;
        run_until_done("c", 1000);
        check("c_enq", 64'(enq_cnt[0]), 64);
        check("c_ovf", 64'(ovf), 0);

        // Leaf 3 with reads every other cycle: charge, read, rsp overlap.
        reset_dut();
        cfg(3, 32'h3000, 40);
        go(1'b1, 1'b1, 1'b1);
        slow_rd = 1'b1;
        start();
        run_until_done("d", 2000);
        check("d_nreq", 64'(rq_addr.size()), 5);
        bad = 0;
        for (int i = 0; i < rq_addr.size(); i++)
            if (rq_addr[i] != 32'h3000 + 32'(8 * i) || rq_len[i] != 8
                || rq_tag[i] != 3) bad++;
        check("d_reqs", 64'(bad), 0);
        check("d_enq", 64'(enq_cnt[3]), 40);
        check("d_ovf", 64'(ovf), 0);

        // Ready held low: request stays put, cfg/start in RUN ignored.
        reset_dut();
        cfg(1, 32'h100, 8);
        cfg(2, 32'h200, 8);
        go(1'b0, 1'b1, 1'b1);
        start();
        tick();
        check("e_valid", 64'(o_req_valid), 1);
        check("e_tag", 64'(o_req_tag), 1);
        h_addr = o_req_addr;
        h_len  = o_req_len;
        h_tag  = o_req_tag;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                i_cfg_valid = 1'b1;
                i_cfg_leaf  = 6'd9;
                i_cfg_addr  = 32'h900;
                i_cfg_len   = 24'd8;
            end
            if (i == 5) i_start = 1'b1;
            tick();
            i_cfg_valid = 1'b0;
            i_start = 1'b0;
            if (!o_req_valid || o_req_addr !== h_addr
                || o_req_len !== h_len || o_req_tag !== h_tag) bad++;
        end
        check("e_hold", 64'(bad), 0);
        ready_en = 1'b1;
        run_until_done("e", 500);
        check("e_nreq", 64'(rq_addr.size()), 2);
        if (rq_addr.size() == 2) begin
            check("e_addr0", 64'(rq_addr[0]), 64'h100);
            check("e_tag1", 64'(rq_tag[1]), 2);
            check("e_addr1", 64'(rq_addr[1]), 64'h200);
            check("e_len1", 64'(rq_len[1]), 8);
        end

        // Reset mid-RUN with 12 items outstanding.
        reset_dut();
        cfg(0, 32'h4000, 12);
        go(1'b1, 1'b0, 1'b1);
        start();
        repeat (6) tick();
        check("f_nreq", 64'(rq_addr.size()), 2);
        ready_en = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("f_req_valid", 64'(o_req_valid), 0);
        check("f_req_fields",
              64'({o_req_addr, o_req_len, o_req_tag}), 0);
        check("f_leaf_out", 64'({o_leaf_write, o_leaf_data}), 0);
        check("f_busy", 64'(o_busy), 0);
        check("f_done", 64'(o_done), 0);
        drop_mode = 1'b1;
        rsp_en = 1'b1;
        repeat (5) tick();
        rsp_en = 1'b0;
        tick();
        drop_mode = 1'b0;
        rspq.delete();
        check("f_dropped", 64'(enq_cnt[0]), 0);
        clear_logs();
        cfg(2, 32'h5000, 8);
        go(1'b1, 1'b1, 1'b1);
        start();
        run_until_done("f", 500);
        check("f_nreq2", 64'(rq_addr.size()), 1);
        if (rq_addr.size() == 1)
            check("f_tag2", 64'(rq_tag[0]), 2);
        check("f_enq", 64'(enq_cnt[2]), 8);

        check("enq_route", 64'(enq_bad), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/merger_leaf_scheduler.md
# merger_leaf_scheduler

Refill scheduler for the 2·L leaf FIFOs that feed the merger tree's first-level MERGER_1 stage. It holds one sorted run (base address, item count) per leaf and keeps per-leaf free-slot credits. It grants burst read requests to the memory port round-robin among leaves with room and data left, then routes tagged read responses into the matching leaf FIFO. It sits between the memory read interface and the tree's `i_fifo` / `i_fifo_empty` / `o_fifo_read` boundary.

## Interface
- NUM_LEAVES, 64: leaf FIFO count (2·L); power of two.
- DATA_WIDTH, 32: item width.
- ADDR_WIDTH, 32: item-granular address width.
- LEN_WIDTH, 24: run length counter width.
- FIFO_DEPTH, 16: leaf FIFO capacity in items.
- BURST, 8: max items per request; must be ≤ FIFO_DEPTH.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_cfg_valid  in  1  write run descriptor (IDLE only; ignored otherwise).
- i_cfg_leaf  in  log2(NUM_LEAVES)  leaf index.
- i_cfg_addr  in  ADDR_WIDTH  run base address.
- i_cfg_len  in  LEN_WIDTH  run length in items.
- i_start  in  1  begin scheduling (IDLE only).
- o_req_valid  out  1  memory read request valid.
- i_req_ready  in  1  memory accepts request.
- o_req_addr  out  ADDR_WIDTH  request address.
- o_req_len  out  log2(BURST)+1  items requested.
- o_req_tag  out  log2(NUM_LEAVES)  destination leaf.
- i_rsp_valid  in  1  one response item valid.
- i_rsp_tag  in  log2(NUM_LEAVES)  response leaf.
- i_rsp_data  in  DATA_WIDTH  response item.
- o_leaf_write  out  NUM_LEAVES  one-hot enqueue to leaf FIFOs.
- o_leaf_data  out  DATA_WIDTH  enqueue data, shared by all leaves.
- i_leaf_read  in  NUM_LEAVES  tree's o_fifo_read, one bit per leaf.
- o_busy  out  1  state is RUN or DRAIN.
- o_done  out  1  one-cycle pulse on entry to DONE.

## Operation
- Per-leaf state: addr, remaining (LEN_WIDTH), credit (0..FIFO_DEPTH).
- States: IDLE → RUN (i_start) → DRAIN (all remaining = 0) → DONE (outstanding = 0, one cycle) → IDLE.
- IDLE: config writes load addr and remaining. i_start sets every credit to FIFO_DEPTH and outstanding to 0.
- Eligibility: remaining ≠ 0 and credit ≥ min(BURST, remaining).
- RUN: when no request is pending, the round-robin arbiter picks the first eligible leaf at or after ptr. The request is registered and the leaf is charged at pick time:
  - addr += n, remaining −= n, credit −= n, where n = min(BURST, remaining);
  - outstanding += n;
  - ptr = granted + 1 mod NUM_LEAVES.
- Credit update when i_leaf_read[k] is set: credit[k] += 1. A same-cycle charge and read on the same leaf nets to credit − n + 1.
- Response: each i_rsp_valid sets o_leaf_write one-hot at i_rsp_tag and o_leaf_data = i_rsp_data, and decrements outstanding. A same-cycle charge and response nets correctly.
- Leaves configured with len 0 are never eligible. Leaves never configured after reset also have remaining 0.
- i_rst from any state returns to IDLE and clears every output and counter, including mid-burst. Responses arriving afterwards are dropped.
- Credit arithmetic guarantees a leaf FIFO never overflows. An item written is never counted free until the tree reads it.

## Timing
- Reset values: o_req_valid = 0, o_req_addr/len/tag = 0, o_leaf_write = 0, o_leaf_data = 0, o_busy = 0, o_done = 0, ptr = 0.
- Request latency: eligibility at cycle t gives o_req_valid at t+1.
- o_req_valid and its fields hold stable until i_req_ready. The next pick happens in the handshake cycle, so back-to-back requests issue every cycle.
- Response-to-enqueue latency is 1 cycle (registered).
- o_busy is 1 in RUN and DRAIN.
- o_done is asserted the cycle after outstanding reaches 0 in DRAIN.
- i_cfg_valid and i_start outside IDLE have no effect.

## Structure
- Shared package (merger_pkg): leaf index width function, request descriptor struct {addr, len, tag}, FSM state enum.
- One sub-module: rr_arbiter (NUM_LEAVES request vector plus ptr → grant index and valid), reusable by later tree controllers.
- Per-leaf addr/remaining/credit arrays and the FSM live in the top.

## Test plan
- Single leaf 5, len 20, BURST 8, others len 0: requests (addr base, len 8), (base+8, 8), (base+16, 4), all tag 5. o_done pulses after the 20th response.
- All 64 leaves len 8, i_req_ready held 1: tags issue 0,1,…,63 on consecutive cycles, then DRAIN.
- Leaf 0 len 64, FIFO_DEPTH 16, no i_leaf_read: exactly 2 requests issue, then stall. Each 8 reads re-enable one more request.
- Same-cycle charge, i_leaf_read and response on leaf 3: credit and outstanding net correctly. The 17th item is never enqueued while the FIFO holds 16.
- i_req_ready low for 10 cycles: o_req_valid, addr, len and tag held constant. No second leaf is charged.
- i_rst asserted mid-RUN with 12 items outstanding: next cycle IDLE, all outputs 0. A new config and i_start completes normally.
